// File: rtl/bank_tracking_cmd_decoder.sv
// Registered DRAM command decoder with per-bank open-row tracking,
// ACT->RD/WR (tRCD) spacing checks and protocol-violation flags.
module bank_tracking_cmd_decoder #(
  parameter int ADDR_W   = 32,
  parameter int ROW_W    = 16,
  parameter int COL_W    = 10,
  parameter int COL_LSB  = 6,
  parameter int BANK_W   = 3,
  parameter int BANK_LSB = 3,
  parameter int T_RCD    = 3
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   chip_select,
  input  logic                   ras,
  input  logic                   cas,
  input  logic                   we,
  output logic [3:0]             cmd_out,
  output logic                   cmd_out_valid,
  output logic [ROW_W-1:0]       row_out,
  output logic [COL_W-1:0]       col_out,
  output logic [BANK_W-1:0]      bank_out,
  output logic [2**BANK_W-1:0]   bank_open,
  output logic                   row_hit,
  output logic                   err_closed,
  output logic                   err_open,
  output logic                   err_trcd,
  output logic                   err_ref,
  output logic [7:0]             err_count
);

  localparam int unsigned NUM_BANKS = 2**BANK_W;
  localparam logic [3:0]  RCD_LOAD  = 4'(T_RCD - 1);

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0, CMD_MRS = 4'd1, CMD_ACT = 4'd2, CMD_REF = 4'd3,
    CMD_PRE = 4'd4, CMD_RD  = 4'd5, CMD_WR  = 4'd6, CMD_BST = 4'd7
  } cmd_e;

  logic [ROW_W-1:0] open_row [NUM_BANKS];
  logic [3:0]       rcd_cnt  [NUM_BANKS];

  cmd_e              cmd_d;
  logic              cmd_valid;
  logic [ROW_W-1:0]  row_f;
  logic [COL_W-1:0]  col_f;
  logic [BANK_W-1:0] bank_f;
  logic              is_act, is_pre, is_rdwr, is_ref;
  logic              sel_open;
  logic              err_closed_d, err_open_d, err_trcd_d, err_ref_d, row_hit_d, any_err;
  // Address bits outside the row/col/bank fields are intentionally ignored.
  logic              addr_unused;

  assign addr_unused = ^addr;

  always_comb begin
    cmd_valid = chip_select & ~(ras & cas & we);
    case ({we, cas, ras})
      3'b000:  cmd_d = CMD_MRS;
      3'b001:  cmd_d = CMD_REF;
      3'b010:  cmd_d = CMD_PRE;
      3'b011:  cmd_d = CMD_RD;
      3'b100:  cmd_d = CMD_ACT;
      3'b101:  cmd_d = CMD_WR;
      3'b110:  cmd_d = CMD_BST;
      default: cmd_d = CMD_NOP;
    endcase

    row_f  = addr[ADDR_W-1 -: ROW_W];
    col_f  = addr[COL_LSB +: COL_W];
    bank_f = addr[BANK_LSB +: BANK_W];

    is_act  = cmd_valid && (cmd_d == CMD_ACT);
    is_pre  = cmd_valid && (cmd_d == CMD_PRE);
    is_ref  = cmd_valid && (cmd_d == CMD_REF);
    is_rdwr = cmd_valid && ((cmd_d == CMD_RD) || (cmd_d == CMD_WR));

    // All checks look at pre-update bank state.
    sel_open     = bank_open[bank_f];
    err_open_d   = is_act && sel_open;
    err_closed_d = (is_rdwr || is_pre) && !sel_open;
    err_trcd_d   = is_rdwr && sel_open && (rcd_cnt[bank_f] != 4'd0);
    err_ref_d    = is_ref && (|bank_open);
    row_hit_d    = is_rdwr && sel_open && (open_row[bank_f] == row_f);
    any_err      = err_open_d | err_closed_d | err_trcd_d | err_ref_d;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cmd_out       <= '0;
      cmd_out_valid <= 1'b0;
      row_out       <= '0;
      col_out       <= '0;
      bank_out      <= '0;
      bank_open     <= '0;
      row_hit       <= 1'b0;
      err_closed    <= 1'b0;
      err_open      <= 1'b0;
      err_trcd      <= 1'b0;
      err_ref       <= 1'b0;
      err_count     <= '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        open_row[b] <= '0;
        rcd_cnt[b]  <= '0;
      end
    end else begin
      cmd_out       <= cmd_valid ? cmd_d : CMD_NOP;
      cmd_out_valid <= cmd_valid;
      row_out       <= row_f;
      col_out       <= col_f;
      bank_out      <= bank_f;
      row_hit       <= row_hit_d;
      err_closed    <= err_closed_d;
      err_open      <= err_open_d;
      err_trcd      <= err_trcd_d;
      err_ref       <= err_ref_d;
      if (any_err && (err_count != '1))
        err_count <= err_count + 8'd1;

      for (int unsigned b = 0; b < NUM_BANKS; b++)
        rcd_cnt[b] <= (rcd_cnt[b] != 4'd0) ? rcd_cnt[b] - 4'd1 : 4'd0;

      // Later assignment overrides the free-running decrement for the activated bank.
      if (is_act && !sel_open) begin
        bank_open[bank_f] <= 1'b1;
        open_row[bank_f]  <= row_f;
        rcd_cnt[bank_f]   <= RCD_LOAD;
      end
      if (is_pre && sel_open)
        bank_open[bank_f] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bank_tracking_cmd_decoder.sv
// Self-checking bench: directed vector table, randomized traffic against a
// cycle-stamp reference model, and saturation / mid-stream reset sequences.
module tb_bank_tracking_cmd_decoder;

  localparam int TB_TRCD = 3;

  localparam logic [2:0] P_MRS = 3'b000, P_REF = 3'b001, P_PRE = 3'b010, P_RD  = 3'b011,
                         P_ACT = 3'b100, P_WR  = 3'b101, P_BST = 3'b110, P_NOP = 3'b111;

  logic        sys_clk, sys_rst;
  logic [31:0] addr;
  logic        chip_select, ras, cas, we;
  logic [3:0]  cmd_out;
  logic        cmd_out_valid;
  logic [15:0] row_out;
  logic [9:0]  col_out;
  logic [2:0]  bank_out;
  logic [7:0]  bank_open;
  logic        row_hit, err_closed, err_open, err_trcd, err_ref;
  logic [7:0]  err_count;

  bank_tracking_cmd_decoder #(
    .ADDR_W(32), .ROW_W(16), .COL_W(10), .COL_LSB(6),
    .BANK_W(3), .BANK_LSB(3), .T_RCD(TB_TRCD)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .addr(addr), .chip_select(chip_select),
    .ras(ras), .cas(cas), .we(we), .cmd_out(cmd_out), .cmd_out_valid(cmd_out_valid),
    .row_out(row_out), .col_out(col_out), .bank_out(bank_out), .bank_open(bank_open),
    .row_hit(row_hit), .err_closed(err_closed), .err_open(err_open),
    .err_trcd(err_trcd), .err_ref(err_ref), .err_count(err_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: open flags, open rows and the cycle each bank was activated.
  logic [3:0]  cmd_tbl [8] = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd2, 4'd6, 4'd7, 4'd0};
  bit          m_open [8];
  logic [15:0] m_row  [8];
  int          m_act  [8];
  int          cyc = 0;
  int          m_cnt = 0;
  logic [3:0]  exp_cmd;
  logic        exp_valid, exp_hit;
  logic [7:0]  exp_open;
  logic [3:0]  exp_err;   // {closed, open, trcd, ref}

  typedef struct {
    logic        cs;
    logic [2:0]  pins;
    logic [2:0]  bank;
    logic [15:0] row;
    logic [3:0]  e_cmd;
    logic        e_valid;
    logic [7:0]  e_open;
    logic        e_hit;
    logic [3:0]  e_err;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mkv(logic cs, logic [2:0] pins, logic [2:0] bank, logic [15:0] row,
                               logic [3:0] c, logic v, logic [7:0] o, logic h,
                               logic [3:0] e, logic [7:0] n);
    vec_t r;
    r.cs = cs; r.pins = pins; r.bank = bank; r.row = row;
    r.e_cmd = c; r.e_valid = v; r.e_open = o; r.e_hit = h; r.e_err = e; r.e_cnt = n;
    return r;
  endfunction

  function automatic logic [31:0] mk_addr(logic [15:0] row, logic [9:0] col, logic [2:0] bank);
    logic [31:0] a;
    a = '0;
    a[31:16] = row;
    a[15:6]  = col;
    a[5:3]   = bank;
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 8; b++) begin
      m_open[b] = 0;
      m_row[b]  = '0;
    end
    m_cnt = 0;
  endtask

  task automatic model_step(input logic cs, input logic [2:0] pins,
                            input logic [2:0] bank, input logic [15:0] row);
    logic [3:0] code;
    code      = cmd_tbl[pins];
    exp_valid = cs && (pins != 3'b111);
    exp_cmd   = exp_valid ? code : 4'd0;
    exp_hit   = 1'b0;
    exp_err   = 4'b0000;
    if (exp_valid) begin
      case (code)
        4'd2: if (m_open[bank]) exp_err[2] = 1'b1;
              else begin m_open[bank] = 1; m_row[bank] = row; m_act[bank] = cyc; end
        4'd5, 4'd6: begin
          if (!m_open[bank]) exp_err[3] = 1'b1;
          else if (cyc - m_act[bank] < TB_TRCD) exp_err[1] = 1'b1;
          exp_hit = m_open[bank] && (m_row[bank] == row);
        end
        4'd4: if (!m_open[bank]) exp_err[3] = 1'b1; else m_open[bank] = 0;
        4'd3: for (int b = 0; b < 8; b++) if (m_open[b]) exp_err[0] = 1'b1;
        default: ;
      endcase
    end
    if (exp_err != 4'b0000 && m_cnt < 255) m_cnt++;
    for (int b = 0; b < 8; b++) exp_open[b] = m_open[b];
    cyc++;
  endtask

  task automatic step(input logic cs, input logic [2:0] pins, input logic [2:0] bank,
                      input logic [15:0] row, input logic [9:0] col);
    chip_select = cs;
    {we, cas, ras} = pins;
    addr = mk_addr(row, col, bank);
    @(posedge sys_clk);
    #1;
    model_step(cs, pins, bank, row);
  endtask

  task automatic check_all(input string tag, input logic [3:0] c, input logic v, input logic [7:0] o,
                           input logic h, input logic [3:0] e, input logic [7:0] n,
                           input logic [15:0] row, input logic [9:0] col, input logic [2:0] bank);
    chk({tag, ".cmd_out"}, 32'(cmd_out), 32'(c));
    chk({tag, ".cmd_out_valid"}, 32'(cmd_out_valid), 32'(v));
    chk({tag, ".bank_open"}, 32'(bank_open), 32'(o));
    chk({tag, ".row_hit"}, 32'(row_hit), 32'(h));
    chk({tag, ".errs"}, 32'({err_closed, err_open, err_trcd, err_ref}), 32'(e));
    chk({tag, ".err_count"}, 32'(err_count), 32'(n));
    if (v) begin
      chk({tag, ".row_out"}, 32'(row_out), 32'(row));
      chk({tag, ".col_out"}, 32'(col_out), 32'(col));
      chk({tag, ".bank_out"}, 32'(bank_out), 32'(bank));
    end
  endtask

  task automatic do_reset(input string tag);
    sys_rst = 1'b1;
    chip_select = 1'b1;
    {we, cas, ras} = P_ACT;
    addr = mk_addr(16'hBEEF, 10'h3, 3'd6);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    model_reset();
    chk({tag, ".cmd_out"}, 32'(cmd_out), 32'h0);
    chk({tag, ".cmd_out_valid"}, 32'(cmd_out_valid), 32'h0);
    chk({tag, ".bank_open"}, 32'(bank_open), 32'h0);
    chk({tag, ".errs"}, 32'({row_hit, err_closed, err_open, err_trcd, err_ref}), 32'h0);
    chk({tag, ".err_count"}, 32'(err_count), 32'h0);
    chk({tag, ".fields"}, 32'({row_out, col_out, bank_out}), 32'h0);
  endtask

  initial begin
    vecs[0]  = mkv(1, P_ACT, 2, 16'h1234, 2, 1, 8'h04, 0, 4'b0000, 0);
    vecs[1]  = mkv(1, P_NOP, 0, 16'h0000, 0, 0, 8'h04, 0, 4'b0000, 0);
    vecs[2]  = mkv(1, P_NOP, 0, 16'h0000, 0, 0, 8'h04, 0, 4'b0000, 0);
    vecs[3]  = mkv(1, P_RD,  2, 16'h1234, 5, 1, 8'h04, 1, 4'b0000, 0);
    vecs[4]  = mkv(1, P_ACT, 1, 16'h0042, 2, 1, 8'h06, 0, 4'b0000, 0);
    vecs[5]  = mkv(1, P_RD,  1, 16'h0042, 5, 1, 8'h06, 1, 4'b0010, 1);
    vecs[6]  = mkv(0, P_MRS, 0, 16'h0000, 0, 0, 8'h06, 0, 4'b0000, 1);
    vecs[7]  = mkv(1, P_RD,  1, 16'h0042, 5, 1, 8'h06, 1, 4'b0000, 1);
    vecs[8]  = mkv(1, P_ACT, 0, 16'h0AAA, 2, 1, 8'h07, 0, 4'b0000, 1);
    vecs[9]  = mkv(1, P_ACT, 0, 16'h0BBB, 2, 1, 8'h07, 0, 4'b0100, 2);
    vecs[10] = mkv(1, P_PRE, 0, 16'h0000, 4, 1, 8'h06, 0, 4'b0000, 2);
    vecs[11] = mkv(1, P_PRE, 0, 16'h0000, 4, 1, 8'h06, 0, 4'b1000, 3);
    vecs[12] = mkv(1, P_ACT, 5, 16'h5555, 2, 1, 8'h26, 0, 4'b0000, 3);
    vecs[13] = mkv(1, P_REF, 0, 16'h0000, 3, 1, 8'h26, 0, 4'b0001, 4);
    vecs[14] = mkv(1, P_PRE, 5, 16'h0000, 4, 1, 8'h06, 0, 4'b0000, 4);
    vecs[15] = mkv(1, P_PRE, 1, 16'h0000, 4, 1, 8'h04, 0, 4'b0000, 4);
    vecs[16] = mkv(1, P_PRE, 2, 16'h0000, 4, 1, 8'h00, 0, 4'b0000, 4);
    vecs[17] = mkv(1, P_REF, 0, 16'h0000, 3, 1, 8'h00, 0, 4'b0000, 4);
    vecs[18] = mkv(0, P_ACT, 3, 16'h3333, 0, 0, 8'h00, 0, 4'b0000, 4);
    vecs[19] = mkv(1, P_NOP, 3, 16'h0000, 0, 0, 8'h00, 0, 4'b0000, 4);
    vecs[20] = mkv(1, P_MRS, 0, 16'h0000, 1, 1, 8'h00, 0, 4'b0000, 4);
    vecs[21] = mkv(1, P_BST, 3, 16'h0000, 7, 1, 8'h00, 0, 4'b0000, 4);
    vecs[22] = mkv(1, P_WR,  3, 16'h0000, 6, 1, 8'h00, 0, 4'b1000, 5);
    vecs[23] = mkv(1, P_ACT, 7, 16'h7777, 2, 1, 8'h80, 0, 4'b0000, 5);
    vecs[24] = mkv(1, P_NOP, 0, 16'h0000, 0, 0, 8'h80, 0, 4'b0000, 5);
    vecs[25] = mkv(1, P_WR,  7, 16'h7777, 6, 1, 8'h80, 1, 4'b0010, 6);
    vecs[26] = mkv(1, P_RD,  7, 16'h1111, 5, 1, 8'h80, 0, 4'b0000, 6);

    sys_rst = 1'b1;
    chip_select = 1'b0;
    {we, cas, ras} = P_NOP;
    addr = '0;
    repeat (2) @(posedge sys_clk);
    do_reset("reset");

    for (int i = 0; i < 27; i++) begin
      logic [9:0] col;
      col = 10'(i * 37 + 5);
      step(vecs[i].cs, vecs[i].pins, vecs[i].bank, vecs[i].row, col);
      check_all($sformatf("vec%0d", i), vecs[i].e_cmd, vecs[i].e_valid, vecs[i].e_open,
                vecs[i].e_hit, vecs[i].e_err, vecs[i].e_cnt, vecs[i].row, col, vecs[i].bank);
    end

    for (int i = 0; i < 500; i++) begin
      logic        cs;
      logic [2:0]  pins, bank;
      logic [15:0] row;
      logic [9:0]  col;
      cs   = ($urandom_range(0, 9) != 0);
      pins = 3'($urandom_range(0, 7));
      bank = 3'($urandom_range(0, 7));
      row  = 16'($urandom_range(0, 3));
      col  = 10'($urandom);
      step(cs, pins, bank, row, col);
      check_all($sformatf("rnd%0d", i), exp_cmd, exp_valid, exp_open, exp_hit, exp_err,
                8'(m_cnt), row, col, bank);
    end

    do_reset("reset2");
    for (int i = 0; i < 300; i++) begin
      logic [2:0] bank;
      bank = 3'($urandom_range(0, 7));
      step(1'b1, P_RD, bank, 16'h00FF, 10'h1);
      check_all($sformatf("sat%0d", i), exp_cmd, exp_valid, exp_open, exp_hit, exp_err,
                8'(m_cnt), 16'h00FF, 10'h1, bank);
    end
    chk("sat.err_count_held", 32'(err_count), 32'd255);

    step(1'b1, P_ACT, 3'd4, 16'h0404, 10'h0);
    check_all("midact4", exp_cmd, exp_valid, exp_open, exp_hit, exp_err, 8'(m_cnt), 16'h0404, 10'h0, 3'd4);
    step(1'b1, P_ACT, 3'd6, 16'h0606, 10'h0);
    check_all("midact6", exp_cmd, exp_valid, exp_open, exp_hit, exp_err, 8'(m_cnt), 16'h0606, 10'h0, 3'd6);
    do_reset("reset_mid");
    step(1'b1, P_RD, 3'd4, 16'h0404, 10'h2);
    check_all("post_reset_rd", 4'd5, 1'b1, 8'h00, 1'b0, 4'b1000, 8'd1, 16'h0404, 10'h2, 3'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
